// File: rtl/ir_pkg.sv
// Shared IR packet definitions for the car transmitter and receiver.
// Nominal lengths are in carrier-pulse units.
package ir_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    GAP,
    BURST
  } rx_state_t;

  localparam logic [2:0] FLD_CAR   = 3'd0;
  localparam logic [2:0] FLD_RIGHT = 3'd1;
  localparam logic [2:0] FLD_LEFT  = 3'd2;
  localparam logic [2:0] FLD_BACK  = 3'd3;
  localparam logic [2:0] FLD_FWD   = 3'd4;

  localparam int NOM_START = 191;
  localparam int NOM_GAP   = 25;
  localparam int NOM_LONG  = 47;
  localparam int NOM_SHORT = 22;

  localparam int CLKS_PER_PULSE_DEF = 2778;

  // COMMAND bit owned by a direction field
  function automatic logic [3:0] fld_mask(
    input logic [2:0] fld
  );
    logic [3:0] m;
    m = 4'b0000;
    unique case (1'b1)
      (fld == FLD_RIGHT): m = 4'b1000;
      (fld == FLD_LEFT):  m = 4'b0100;
      (fld == FLD_BACK):  m = 4'b0010;
      (fld == FLD_FWD):   m = 4'b0001;
      default:            m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ir_rx_filter.sv
// IR envelope synchroniser and glitch filter with edge strobes.
// Both edges see the same delay, so measured widths are preserved.
module ir_rx_filter #(
  parameter int FILTER_CLKS = 16
) (
  input  logic CLK,
  input  logic RESET,
  input  logic ir_rx,
  output logic rx_filt,
  output logic rx_rise,
  output logic rx_fall
);

  localparam int CW = $clog2(FILTER_CLKS + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      cnt     <= '0;
      rx_filt <= 1'b0;
      rx_rise <= 1'b0;
      rx_fall <= 1'b0;
    end else begin
      sync1   <= ir_rx;
      sync2   <= sync1;
      rx_rise <= 1'b0;
      rx_fall <= 1'b0;
      if (sync2 == rx_filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_CLKS - 1)) begin
        cnt     <= '0;
        rx_filt <= sync2;
        rx_rise <= sync2;
        rx_fall <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ir_packet_receiver.sv
// Car IR packet decoder: measures bursts and gaps in carrier pulses
// and recovers the 4-bit direction command.
module ir_packet_receiver
  import ir_pkg::*;
#(
  parameter int CLKS_PER_PULSE = CLKS_PER_PULSE_DEF,
  parameter int FILTER_CLKS    = 16,
  parameter int START_MIN      = 160,
  parameter int START_MAX      = 220,
  parameter int LONG_MIN       = 35,
  parameter int LONG_MAX       = 60,
  parameter int SHORT_MIN      = 12,
  parameter int GAP_MIN        = 15,
  parameter int GAP_MAX        = 40
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       IR_RX,
  output logic [3:0] COMMAND,
  output logic       PACKET_VALID,
  output logic       RX_ERROR,
  output logic       BUSY
);

  localparam logic [11:0] TICK_LAST = 12'(CLKS_PER_PULSE - 1);

  logic        rx_filt;
  logic        rx_rise;
  logic        rx_fall;
  logic [11:0] tick_cnt;
  logic [7:0]  pulse_cnt;
  logic        tick_wrap;
  logic [7:0]  len;
  logic        in_start;
  logic        in_long;
  logic        in_short;

  rx_state_t   state_q;
  rx_state_t   state_d;
  logic [2:0]  fld_q;
  logic [2:0]  fld_d;
  logic [3:0]  shadow_q;
  logic [3:0]  shadow_d;
  logic        err_d;
  logic        valid_d;

  ir_rx_filter #(
    .FILTER_CLKS(FILTER_CLKS)
  ) u_filter (
    .CLK    (CLK),
    .RESET  (RESET),
    .ir_rx  (IR_RX),
    .rx_filt(rx_filt),
    .rx_rise(rx_rise),
    .rx_fall(rx_fall)
  );

  assign tick_wrap = (tick_cnt == TICK_LAST);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tick_cnt  <= '0;
      pulse_cnt <= '0;
    end else if (rx_rise || rx_fall) begin
      tick_cnt  <= '0;
      pulse_cnt <= '0;
    end else if (tick_wrap) begin
      tick_cnt <= '0;
      if (pulse_cnt != 8'hFF) pulse_cnt <= pulse_cnt + 8'd1;
    end else begin
      tick_cnt <= tick_cnt + 12'd1;
    end
  end

  // Edge cycle is part of the segment, so fold in its pending wrap
  assign len = (tick_wrap && pulse_cnt != 8'hFF) ?
               pulse_cnt + 8'd1 : pulse_cnt;

  assign in_start = (len >= 8'(START_MIN)) && (len <= 8'(START_MAX));
  assign in_long  = (len >= 8'(LONG_MIN)) && (len <= 8'(LONG_MAX));
  assign in_short = (len >= 8'(SHORT_MIN)) && (len < 8'(LONG_MIN));

  always_comb begin
    state_d  = state_q;
    fld_d    = fld_q;
    shadow_d = shadow_q;
    err_d    = 1'b0;
    valid_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_rise) begin
          state_d  = START;
          shadow_d = 4'b0000;
        end
      end
      START: begin
        if (rx_fall) begin
          state_d = in_start ? GAP : IDLE;
          fld_d   = FLD_CAR;
        end
      end
      GAP: begin
        if (rx_rise) begin
          if (len < 8'(GAP_MIN)) begin
            err_d    = 1'b1;
            state_d  = START;
            shadow_d = 4'b0000;
          end else if (len > 8'(GAP_MAX)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = BURST;
          end
        end else if (!rx_filt && pulse_cnt > 8'(GAP_MAX)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      BURST: begin
        if (rx_fall) begin
          if (fld_q == FLD_CAR) begin
            if (in_long) begin
              state_d = GAP;
              fld_d   = fld_q + 3'd1;
            end else begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end else if (in_long || in_short) begin
            shadow_d = in_long ? (shadow_q | fld_mask(fld_q)) :
                                 (shadow_q & ~fld_mask(fld_q));
            if (fld_q == FLD_FWD) begin
              valid_d = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = GAP;
              fld_d   = fld_q + 3'd1;
            end
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      fld_q        <= FLD_CAR;
      shadow_q     <= 4'b0000;
      COMMAND      <= 4'b0000;
      PACKET_VALID <= 1'b0;
      RX_ERROR     <= 1'b0;
    end else begin
      state_q      <= state_d;
      fld_q        <= fld_d;
      shadow_q     <= shadow_d;
      PACKET_VALID <= valid_d;
      RX_ERROR     <= err_d;
      if (valid_d) COMMAND <= shadow_d;
    end
  end

  assign BUSY = (state_q != IDLE);

endmodule

// File: tb/tb_ir_packet_receiver.sv
// Self-checking bench for ir_packet_receiver: packet table plus
// hand-written timeout, glitch and reset sequences.
module tb_ir_packet_receiver;
  import ir_pkg::*;

  localparam int CPP = 6;
  localparam int FLT = 16;

  logic       CLK;
  logic       RESET;
  logic       IR_RX;
  logic [3:0] COMMAND;
  logic       PACKET_VALID;
  logic       RX_ERROR;
  logic       BUSY;

  ir_packet_receiver #(
    .CLKS_PER_PULSE(CPP),
    .FILTER_CLKS   (FLT)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .IR_RX       (IR_RX),
    .COMMAND     (COMMAND),
    .PACKET_VALID(PACKET_VALID),
    .RX_ERROR    (RX_ERROR),
    .BUSY        (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pv_seen = 0;
  int err_seen = 0;
  int last_err_cyc = 0;
  logic [3:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Scoreboard side: every strobe is matched against expectations
  always @(negedge CLK) begin
    if (PACKET_VALID || RX_ERROR)
      chk("valid_err_exclusive", int'(PACKET_VALID && RX_ERROR), 0);
    if (RX_ERROR) begin
      err_seen++;
      last_err_cyc = cyc;
    end
    if (PACKET_VALID) begin
      pv_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        chk("sb_command", int'(COMMAND), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic seg(input logic v, input int n, input bit glitch);
    int total;
    int half;
    total = n * CPP;
    half  = total / 2;
    IR_RX = v;
    if (glitch) begin
      repeat (half) @(negedge CLK);
      IR_RX = ~v;
      repeat (5) @(negedge CLK);
      IR_RX = v;
      repeat (total - half - 5) @(negedge CLK);
    end else begin
      repeat (total) @(negedge CLK);
    end
  endtask

  task automatic send(input int st, input int car, input int r,
                      input int l, input int bk, input int f,
                      input int gap, input bit glitch);
    seg(1'b1, st, 1'b0);
    seg(1'b0, gap, glitch);
    seg(1'b1, car, glitch);
    seg(1'b0, gap, 1'b0);
    seg(1'b1, r, 1'b0);
    seg(1'b0, gap, 1'b0);
    seg(1'b1, l, 1'b0);
    seg(1'b0, gap, 1'b0);
    seg(1'b1, bk, 1'b0);
    seg(1'b0, gap, 1'b0);
    seg(1'b1, f, 1'b0);
    seg(1'b0, gap, 1'b0);
  endtask

  typedef struct {
    string      name;
    int         st;
    int         car;
    int         r;
    int         l;
    int         bk;
    int         f;
    int         gap;
    bit         v;
    bit         e;
    logic [3:0] cmd;
  } vec_t;

  localparam int NV = 13;
  vec_t tbl[NV];

  initial begin
    int pv0;
    int e0;
    int t0;
    int dt;

    tbl[0]  = '{"nominal", NOM_START, NOM_LONG, 47, 22, 22, 47,
                NOM_GAP, 1'b1, 1'b0, 4'b1001};
    tbl[1]  = '{"all_zero", 191, 47, 22, 22, 22, 22, 25, 1'b1, 1'b0, 4'b0000};
    tbl[2]  = '{"all_one", 191, 47, 47, 47, 47, 47, 25, 1'b1, 1'b0, 4'b1111};
    tbl[3]  = '{"left_80", 191, 47, 47, 80, 22, 47, 25, 1'b0, 1'b1, 4'b1111};
    tbl[4]  = '{"start_100", 100, 47, 47, 22, 22, 47, 25, 1'b0, 1'b0, 4'b1111};
    tbl[5]  = '{"bounds_lo", 160, 35, 35, 34, 12, 60, 15, 1'b1, 1'b0, 4'b1001};
    tbl[6]  = '{"bounds_hi", 220, 60, 60, 60, 12, 12, 40, 1'b1, 1'b0, 4'b1100};
    tbl[7]  = '{"start_221", 221, 47, 47, 47, 47, 47, 25, 1'b0, 1'b0, 4'b1100};
    tbl[8]  = '{"start_159", 159, 47, 47, 47, 47, 47, 25, 1'b0, 1'b0, 4'b1100};
    tbl[9]  = '{"right_11", 191, 47, 11, 22, 22, 47, 25, 1'b0, 1'b1, 4'b1100};
    tbl[10] = '{"fwd_61", 191, 47, 47, 47, 47, 61, 25, 1'b0, 1'b1, 4'b1100};
    tbl[11] = '{"car_34", 191, 34, 47, 47, 47, 47, 25, 1'b0, 1'b1, 4'b1100};
    tbl[12] = '{"gap_14", 191, 47, 47, 47, 47, 47, 14, 1'b0, 1'b1, 4'b1100};

    RESET = 1'b1;
    IR_RX = 1'b0;
    repeat (4) @(negedge CLK);
    chk("reset_command", int'(COMMAND), 0);
    chk("reset_valid", int'(PACKET_VALID), 0);
    chk("reset_error", int'(RX_ERROR), 0);
    chk("reset_busy", int'(BUSY), 0);
    RESET = 1'b0;
    seg(1'b0, 10, 1'b0);

    for (int i = 0; i < NV; i++) begin
      pv0 = pv_seen;
      e0  = err_seen;
      if (tbl[i].v) exp_q.push_back(tbl[i].cmd);
      send(tbl[i].st, tbl[i].car, tbl[i].r, tbl[i].l, tbl[i].bk,
           tbl[i].f, tbl[i].gap, 1'b0);
      seg(1'b0, 100, 1'b0);
      chk({tbl[i].name, "_valids"}, pv_seen - pv0, int'(tbl[i].v));
      chk({tbl[i].name, "_errors"}, err_seen - e0, int'(tbl[i].e));
      chk({tbl[i].name, "_command"}, int'(COMMAND), int'(tbl[i].cmd));
      chk({tbl[i].name, "_busy"}, int'(BUSY), 0);
    end

    // Gap held low past GAP_MAX after Start and CarSelect
    exp_q.push_back(4'b1001);
    send(191, 47, 47, 22, 22, 47, 25, 1'b0);
    seg(1'b0, 20, 1'b0);
    pv0 = pv_seen;
    e0  = err_seen;
    seg(1'b1, 191, 1'b0);
    seg(1'b0, 25, 1'b0);
    seg(1'b1, 47, 1'b0);
    t0 = cyc;
    seg(1'b0, 60, 1'b0);
    chk("gap60_errors", err_seen - e0, 1);
    chk("gap60_valids", pv_seen - pv0, 0);
    dt = last_err_cyc - t0;
    chk("gap60_err_timing_ok",
        int'(dt >= 41 * CPP && dt <= 41 * CPP + FLT + 8), 1);
    if (!(dt >= 41 * CPP && dt <= 41 * CPP + FLT + 8))
      $display("  gap60 error came %0d cycles after burst end", dt);
    chk("gap60_busy", int'(BUSY), 0);
    chk("gap60_command", int'(COMMAND), 4'b1001);
    seg(1'b0, 40, 1'b0);

    // Sub-filter glitches inside a gap and a burst
    e0 = err_seen;
    exp_q.push_back(4'b1010);
    send(191, 47, 47, 22, 47, 22, 25, 1'b1);
    seg(1'b0, 40, 1'b0);
    chk("glitch_command", int'(COMMAND), 4'b1010);
    chk("glitch_errors", err_seen - e0, 0);

    // Reset during the Backward burst
    pv0 = pv_seen;
    seg(1'b1, 191, 1'b0);
    seg(1'b0, 25, 1'b0);
    seg(1'b1, 47, 1'b0);
    seg(1'b0, 25, 1'b0);
    seg(1'b1, 47, 1'b0);
    seg(1'b0, 25, 1'b0);
    seg(1'b1, 47, 1'b0);
    seg(1'b0, 25, 1'b0);
    seg(1'b1, 20, 1'b0);
    chk("pre_reset_busy", int'(BUSY), 1);
    RESET = 1'b1;
    IR_RX = 1'b0;
    #1;
    chk("midreset_command", int'(COMMAND), 0);
    chk("midreset_busy", int'(BUSY), 0);
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    seg(1'b0, 30, 1'b0);
    chk("midreset_no_valid", pv_seen - pv0, 0);
    exp_q.push_back(4'b0110);
    send(191, 47, 22, 47, 47, 22, 25, 1'b0);
    seg(1'b0, 40, 1'b0);
    chk("post_reset_command", int'(COMMAND), 4'b0110);
    chk("post_reset_valids", pv_seen - pv0, 1);

    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
